// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and debounces qa/qb, decodes Gray transitions into step/dir pulses and keeps a wrapping count.
// Define QSD_ERR_DETECT_EN to latch err on double-bit (illegal) transitions; otherwise err is tied to 0.
module quad_step_decoder #(
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2,  // minimum 2
  parameter int FILT_LEN    = 4   // minimum 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             qa,
  input  logic             qb,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int IW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               init_cnt_q, init_cnt_d;
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  synced;
  logic [1:0]                  filt_q, filt_d;
  logic [1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [1:0]                  prev_q, prev_d;
  logic                        step_q, step_d;
  logic                        dir_q, dir_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [1:0]                  delta;
  logic                        is_up;
  logic                        is_dn;
`ifdef QSD_ERR_DETECT_EN
  logic                        err_q, err_d;
  logic                        is_bad;
`endif

  // Position along the up sequence 00->10->11->01; a difference of 2 means both bits moved.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  assign raw   = {qa, qb};
  assign delta = gray_pos(filt_q) - gray_pos(prev_q);
  assign is_up = (delta == 2'd1);
  assign is_dn = (delta == 2'd3);
`ifdef QSD_ERR_DETECT_EN
  assign is_bad = (delta == 2'd2);
`endif

  always_comb begin
    sync_d = sync_q;
    synced = '0;
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      synced[ch] = sync_q[ch][SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    prev_d     = prev_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    count_d    = count_q;
`ifdef QSD_ERR_DETECT_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_INIT: begin
        // Filter and prev both follow the synchroniser so RUN starts with no pending transition.
        filt_d = synced;
        prev_d = synced;
        fcnt_d = '0;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ST_RUN: begin
        for (int ch = 0; ch < 2; ch++) begin
          if (synced[ch] == filt_q[ch]) begin
            fcnt_d[ch] = '0;
          end else if (fcnt_q[ch] == FILT_LAST) begin
            filt_d[ch] = synced[ch];
            fcnt_d[ch] = '0;
          end else begin
            fcnt_d[ch] = fcnt_q[ch] + FW'(1);
          end
        end
        // prev keeps tracking with en low so re-enabling never replays old motion.
        prev_d = filt_q;
        if (en) begin
          if (is_up) begin
            step_d  = 1'b1;
            dir_d   = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else if (is_dn) begin
            step_d  = 1'b1;
            dir_d   = 1'b0;
            count_d = count_q - CNT_W'(1);
          end
`ifdef QSD_ERR_DETECT_EN
          if (is_bad) begin
            err_d = 1'b1;
          end
`endif
        end
      end
    endcase
    if (clr) begin
      count_d = '0;
`ifdef QSD_ERR_DETECT_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      sync_q     <= '0;
      filt_q     <= '0;
      fcnt_q     <= '0;
      prev_q     <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
    end
  end

`ifdef QSD_ERR_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign step  = step_q;
  assign dir   = dir_q;
  assign count = count_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: scoreboard of expected step events (cycle, dir, count) checked as pulses appear.
module tb_quad_step_decoder;

  localparam int CNT_W       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  // Drive happens after edge c; first sampling edge is c+1; step registers on edge c+1+SYNC+FILT.
  localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;

  typedef struct {
    int               cyc;
    logic             dir;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             qa;
  logic             qb;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic             err;

  int               cyc;
  int               n_checks;
  int               n_fail;
  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [1:0]       model_ab;
  logic [CNT_W-1:0] model_count;
  logic             model_dir;
  logic             model_err;

  quad_step_decoder #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (clr),
    .qa   (qa),
    .qb   (qb),
    .step (step),
    .dir  (dir),
    .count(count),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // 1 = up, -1 = down, 0 = no change, 2 = both bits changed.
  function automatic int classify(input logic [1:0] p, input logic [1:0] n);
    logic [1:0] up_p;
    logic [1:0] up_n;
    case (p)
      2'b00:   up_p = 2'b10;
      2'b10:   up_p = 2'b11;
      2'b11:   up_p = 2'b01;
      default: up_p = 2'b00;
    endcase
    case (n)
      2'b00:   up_n = 2'b10;
      2'b10:   up_n = 2'b11;
      2'b11:   up_n = 2'b01;
      default: up_n = 2'b00;
    endcase
    if (n == p)         return 0;
    else if (n == up_p) return 1;
    else if (up_n == p) return -1;
    else                return 2;
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold must be at least FILT_LEN so the new level is accepted by the filter.
  task automatic drive_ab(input logic [1:0] ab, input int hold, input bit clr_with_step);
    int   c;
    int   kind;
    exp_t e;
    @(posedge clk);
    #1;
    c    = cyc;
    qa   = ab[1];
    qb   = ab[0];
    kind = classify(model_ab, ab);
    if (en && (kind == 1 || kind == -1)) begin
      model_dir = (kind == 1);
      if (clr_with_step) begin
        model_count = '0;
        model_err   = 1'b0;
      end else if (kind == 1) begin
        model_count = model_count + CNT_W'(1);
      end else begin
        model_count = model_count - CNT_W'(1);
      end
      e.cyc = c + LAT;
      e.dir = model_dir;
      e.cnt = model_count;
      exp_q.push_back(e);
    end
`ifdef QSD_ERR_DETECT_EN
    if (en && kind == 2) model_err = 1'b1;
`endif
    model_ab = ab;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (clr_with_step && i == LAT - 1) clr = 1'b1;
      if (clr_with_step && i == LAT)     clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr         = 1'b0;
    model_count = '0;
    model_err   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(model_count));
    check({tag, "_dir"},   32'(dir),   32'(model_dir));
    check({tag, "_err"},   32'(err),   32'(model_err));
  endtask

  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_step", 32'(step), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("step_cycle", 32'(cyc),   32'(mon_e.cyc));
        check("step_dir",   32'(dir),   32'(mon_e.dir));
        check("step_count", 32'(count), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    en          = 1'b1;
    clr         = 1'b0;
    qa          = 1'b1;
    qb          = 1'b1;
    model_ab    = 2'b11;
    model_count = '0;
    model_dir   = 1'b0;
    model_err   = 1'b0;

    wait_cycles(3);
    check("rst_step",  32'(step),  32'd0);
    check("rst_dir",   32'(dir),   32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    rst_n = 1'b1;
    wait_cycles(30);
    check_state("init_11");

    // From 11 back to 00 along the up sequence.
    drive_ab(2'b01, 10, 1'b0);
    drive_ab(2'b00, 10, 1'b0);
    check_state("to_00");
    pulse_clr();
    check_state("clr0");

    drive_ab(2'b10, 10, 1'b0);
    drive_ab(2'b11, 10, 1'b0);
    drive_ab(2'b01, 10, 1'b0);
    drive_ab(2'b00, 10, 1'b0);
    check_state("up4");
    pulse_clr();
    check_state("clr1");

    drive_ab(2'b01, 10, 1'b0);
    check_state("down_wrap");
    drive_ab(2'b11, 10, 1'b0);
    drive_ab(2'b10, 10, 1'b0);
    drive_ab(2'b00, 10, 1'b0);
    check_state("down4");

    // Three-cycle glitch on A must be rejected.
    @(posedge clk);
    #1;
    qa = 1'b1;
    wait_cycles(3);
    qa = 1'b0;
    wait_cycles(12);
    check_state("glitch3");
    drive_ab(2'b10, 4, 1'b0);
    drive_ab(2'b00, 12, 1'b0);
    check_state("glitch4");

    @(posedge clk);
    #1;
    en = 1'b0;
    drive_ab(2'b10, 10, 1'b0);
    drive_ab(2'b11, 10, 1'b0);
    en = 1'b1;
    wait_cycles(12);
    check_state("en_off");
    drive_ab(2'b01, 10, 1'b0);
    check_state("en_back");
    drive_ab(2'b00, 10, 1'b1);
    check_state("clr_step");

    drive_ab(2'b11, 10, 1'b0);
    check_state("illegal");
    pulse_clr();
    check_state("illegal_clr");
    drive_ab(2'b01, 10, 1'b0);
    drive_ab(2'b00, 10, 1'b0);
    check_state("post_illegal");

    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    model_count = '0;
    model_dir   = 1'b0;
    model_err   = 1'b0;
    #1;
    check_state("mid_rst");
    check("mid_rst_step", 32'(step), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(12);
    check_state("after_rst");
    check("pending_steps", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
